// File: rtl/serial_magnitude_comparator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_magnitude_comparator_pkg
// Brief    : Shared state encodings, default width and result encodings for
//            the bit-serial magnitude comparator.
// Revision : 1.0 - initial release
// ============================================================================
package serial_magnitude_comparator_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Result flags packed as {eq, a_gt_b, b_gt_a}
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_EQ   = 3'b100;
    localparam logic [2:0] RES_AGTB = 3'b010;
    localparam logic [2:0] RES_BGTA = 3'b001;

endpackage : serial_magnitude_comparator_pkg
`default_nettype wire

// File: rtl/serial_magnitude_comparator_bit_compare_slice.sv
`default_nettype none
// ============================================================================
// Module   : bit_compare_slice
// Brief    : Combinational one-bit magnitude compare slice (MSB-first chain).
//            Behavioural twin of the gate-level slice.
// Revision : 1.0 - initial release
// ============================================================================
module bit_compare_slice (
    input  logic ai_i,
    input  logic bi_i,
    input  logic e0_i,
    input  logic g0_i,
    output logic e1_o,
    output logic g1_o
);

    // g tracks "B greater so far"; it can only be set while still equal.
    assign e1_o = e0_i & ~(ai_i ^ bi_i);
    assign g1_o = g0_i | (~ai_i & bi_i & e0_i);

endmodule : bit_compare_slice
`default_nettype wire

// File: rtl/serial_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module   : serial_magnitude_comparator
// Brief    : Bit-serial unsigned A/B magnitude comparator, MSB first.
//            Optional macro SERIAL_CMP_EARLY_EXIT_EN finishes on first
//            differing bit.
// Revision : 1.0 - initial release
// ============================================================================
module serial_magnitude_comparator
    import serial_magnitude_comparator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             eq_o,
    output logic             a_gt_b_o,
    output logic             b_gt_a_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               e_q, e_d;
    logic               g_q, g_d;
    logic               eq_q, eq_d;
    logic               agtb_q, agtb_d;
    logic               bgta_q, bgta_d;

    logic               slice_e;
    logic               slice_g;
    logic               last_bit;
    logic               finish;

    bit_compare_slice u_slice (
        .ai_i (sa_q[WIDTH-1]),
        .bi_i (sb_q[WIDTH-1]),
        .e0_i (e_q),
        .g0_i (g_q),
        .e1_o (slice_e),
        .g1_o (slice_g)
    );

    assign last_bit = (cnt_q == CNT_W'(1));

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    assign finish = last_bit | ~slice_e;
`else
    assign finish = last_bit;
`endif

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        g_d     = g_q;
        eq_d    = eq_q;
        agtb_d  = agtb_q;
        bgta_d  = bgta_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_SHIFT;
                    sa_d    = a_i;
                    sb_d    = b_i;
                    cnt_d   = CNT_W'(WIDTH);
                    e_d     = 1'b1;
                    g_d     = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                e_d   = slice_e;
                g_d   = slice_g;
                sa_d  = sa_q << 1;
                sb_d  = sb_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (finish) begin
                    state_d = ST_DONE;
                    eq_d    = slice_e;
                    bgta_d  = slice_g;
                    agtb_d  = ~slice_e & ~slice_g;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            e_q     <= 1'b1;
            g_q     <= 1'b0;
            eq_q    <= 1'b0;
            agtb_q  <= 1'b0;
            bgta_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            g_q     <= g_d;
            eq_q    <= eq_d;
            agtb_q  <= agtb_d;
            bgta_q  <= bgta_d;
        end
    end

    assign busy_o   = (state_q == ST_SHIFT);
    assign done_o   = (state_q == ST_DONE);
    assign eq_o     = eq_q;
    assign a_gt_b_o = agtb_q;
    assign b_gt_a_o = bgta_q;

endmodule : serial_magnitude_comparator
`default_nettype wire

// File: tb/tb_serial_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_magnitude_comparator
// Brief    : Self-checking bench for serial_magnitude_comparator (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_magnitude_comparator;
    import serial_magnitude_comparator_pkg::*;

    localparam int W       = 8;
    localparam int MAX_LAT = 40;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic [W-1:0] a_i, b_i;
    logic         busy_o, done_o, eq_o, a_gt_b_o, b_gt_a_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   res;
    } vec_t;

    vec_t vecs [8];

    serial_magnitude_comparator #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .eq_o     (eq_o),
        .a_gt_b_o (a_gt_b_o),
        .b_gt_a_o (b_gt_a_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        lat = W;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        for (int i = W - 1; i >= 0; i--) begin
            if (a[i] != b[i]) begin
                lat = W - i;
                break;
            end
        end
`endif
        return lat;
    endfunction

    function automatic logic [2:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == b)     return RES_EQ;
        else if (a > b) return RES_AGTB;
        else            return RES_BGTA;
    endfunction

    function automatic logic [2:0] flags();
        return {eq_o, a_gt_b_o, b_gt_a_o};
    endfunction

    // Called at a negedge: start is sampled at the following posedge (edge 0).
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        start_i = 1'b1;
        a_i     = a;
        b_i     = b;
        @(negedge clk);
        start_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
    endtask

    // Called at the negedge just after edge 0; returns at the negedge with done high.
    task automatic wait_done(input string tag, input int lat_exp);
        int lat;
        int nbusy;
        lat   = 0;
        nbusy = 0;
        while (!done_o && lat < MAX_LAT) begin
            nbusy += int'(busy_o);
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, lat_exp);
        check({tag, " busy cycles"}, nbusy, lat_exp);
        check({tag, " busy low at done"}, busy_o, 1'b0);
    endtask

    task automatic run_pair(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2:0] res);
        launch(a, b);
        wait_done(tag, exp_lat(a, b));
        check({tag, " result"}, flags(), res);
        @(negedge clk);
        check({tag, " done one cycle"}, done_o, 1'b0);
        check({tag, " result held"}, flags(), res);
    endtask

    initial begin
        logic [W-1:0] ra, rb;

        vecs[0] = '{8'h5A, 8'h5A, RES_EQ};
        vecs[1] = '{8'h80, 8'h7F, RES_AGTB};
        vecs[2] = '{8'h12, 8'h13, RES_BGTA};
        vecs[3] = '{8'h00, 8'h00, RES_EQ};
        vecs[4] = '{8'hFF, 8'hFF, RES_EQ};
        vecs[5] = '{8'hFE, 8'hFF, RES_BGTA};
        vecs[6] = '{8'h01, 8'h00, RES_AGTB};
        vecs[7] = '{8'h7F, 8'h80, RES_BGTA};

        rst_n   = 1'b0;
        start_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        repeat (3) @(negedge clk);
        check("reset busy", busy_o, 1'b0);
        check("reset done", done_o, 1'b0);
        check("reset flags", flags(), RES_NONE);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle flags", flags(), RES_NONE);

        for (int i = 0; i < 8; i++)
            run_pair($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res);

        // start during SHIFT is ignored, then back-to-back restart from DONE
        launch(8'h10, 8'h20);
        repeat (2) @(negedge clk);
        start_i = 1'b1;
        a_i     = 8'hFF;
        b_i     = 8'h00;
        @(negedge clk);
        start_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        wait_done("ignored start", exp_lat(8'h10, 8'h20) - 3);
        check("ignored start result", flags(), RES_BGTA);
        launch(8'hFF, 8'h00);
        check("b2b busy no gap", busy_o, 1'b1);
        check("b2b flags held", flags(), RES_BGTA);
        wait_done("b2b", exp_lat(8'hFF, 8'h00));
        check("b2b result", flags(), RES_AGTB);
        @(negedge clk);

        // asynchronous reset mid-SHIFT
        launch(8'hAA, 8'h55);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", busy_o, 1'b0);
        check("abort done", done_o, 1'b0);
        check("abort flags", flags(), RES_NONE);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-abort no done", done_o, 1'b0);
        check("post-abort flags", flags(), RES_NONE);
        run_pair("post-abort zero", 8'h00, 8'h00, RES_EQ);

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = (i % 8 == 0) ? ra : W'($urandom);
            launch(ra, rb);
            wait_done($sformatf("rand%0d", i), exp_lat(ra, rb));
            check($sformatf("rand%0d %02h/%02h", i, ra, rb), flags(), ref_res(ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_serial_magnitude_comparator
`default_nettype wire
